// File: rtl/fb_pixel_writer_pkg.sv
// Shared framebuffer definitions used by the pixel writer and the VGA scan-out path.
//   FRAME_PIXELS / ADDR_W / DATA_W : framebuffer geometry (one byte per pixel)
//   TIMEOUT                         : SRAM completion wait limit, in cycles
//   RED/GREEN/BLUE_LSB, *_W         : RGB332 field layout
//   fb_state_t                      : pixel-writer FSM encoding
package fb_pixel_writer_pkg;

    localparam int unsigned FRAME_PIXELS = 480000;
    localparam int unsigned ADDR_W       = 19;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned TIMEOUT      = 255;

    // RGB332: [7:5] blue, [4:3] green, [2:0] red
    localparam int unsigned RED_LSB   = 0;
    localparam int unsigned RED_W     = 3;
    localparam int unsigned GREEN_LSB = 3;
    localparam int unsigned GREEN_W   = 2;
    localparam int unsigned BLUE_LSB  = 5;
    localparam int unsigned BLUE_W    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } fb_state_t;

    function automatic logic [DATA_W-1:0] rgb332(input logic [RED_W-1:0]   r,
                                                 input logic [GREEN_W-1:0] g,
                                                 input logic [BLUE_W-1:0]  b);
        return {b, g, r};
    endfunction

endpackage

// File: rtl/fb_addr_counter.sv
// Wrapping framebuffer address counter.
//   clk, rst : clock, synchronous active-low reset
//   clr      : force address to 0 (wins over inc)
//   inc      : advance one pixel; wraps from NUM_PIXELS-1 to 0 by explicit compare
//   addr     : current address, always in 0..NUM_PIXELS-1
//   wrap     : high in the cycle inc is applied at the last address (even if clr
//              overrides the value), so the frame end is reported regardless
module fb_addr_counter
    import fb_pixel_writer_pkg::*;
#(
    parameter int unsigned NUM_PIXELS = FRAME_PIXELS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              wrap
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    logic at_last;

    assign at_last = (addr == LAST_ADDR);
    assign wrap    = inc & at_last;

    // NOTE: clocked state is assigned with non-blocking (<=) so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr <= '0;
        end else if (clr) begin
            addr <= '0;
        end else if (inc) begin
            addr <= at_last ? '0 : addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/fb_pixel_writer.sv
// Write-side client of the SRAM framebuffer.
// Takes an RGB332 pixel stream (valid/ready) or a full-frame clear request and
// issues one byte-write per pixel to the SRAM controller at sequential addresses.
//   clk, rst                     : clock, synchronous active-low reset
//   sof_in                       : next pixel goes to address 0
//   pix_valid_in/pix_data_in     : pixel stream input
//   pix_ready_out                : pixel accepted this cycle when valid & ready
//   clear_in/clear_color_in      : start a fill of the whole frame with one colour
//   busy_out                     : transaction or clear in progress
//   frame_done_out               : pulse after the last frame address completes
//   err_timeout_out              : sticky, done_in never came within the timeout
//   trig_out/rw_out/addr_out/w_data_out/done_in : SRAM controller request interface
module fb_pixel_writer
    import fb_pixel_writer_pkg::*;
#(
    parameter int unsigned NUM_PIXELS     = FRAME_PIXELS,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sof_in,
    input  logic              pix_valid_in,
    input  logic [DATA_W-1:0] pix_data_in,
    output logic              pix_ready_out,
    input  logic              clear_in,
    input  logic [DATA_W-1:0] clear_color_in,
    output logic              busy_out,
    output logic              frame_done_out,
    output logic              err_timeout_out,
    output logic              trig_out,
    output logic              rw_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] w_data_out,
    input  logic              done_in
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    fb_state_t         state;
    logic              clear_mode;
    logic [DATA_W-1:0] clear_color;
    logic              pend_sof;
    logic              pend_clr;
    logic [TMO_W-1:0]  tmo_cnt;

    logic [ADDR_W-1:0] cnt_addr;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              cnt_wrap;

    logic              accept_pix;
    logic              timed_out;
    logic              finish;
    logic              eff_sof;
    logic              eff_clr;
    logic [ADDR_W-1:0] issue_addr;

    fb_addr_counter #(
        .NUM_PIXELS (NUM_PIXELS)
    ) u_addr_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .addr (cnt_addr),
        .wrap (cnt_wrap)
    );

    // NOTE: every signal driven here gets a default first, so no path through the
    // block leaves a value unassigned and no latch is inferred.
    always_comb begin
        // clear_in masks ready in its own cycle so a coincident pixel is refused
        pix_ready_out = rst && (state == IDLE) && !clear_mode && !clear_in;
        accept_pix    = pix_valid_in && pix_ready_out;
        timed_out     = (state == WAIT) && !done_in &&
                        (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
        finish        = (state == WAIT) && (done_in || timed_out);
        // requests arriving on the finishing cycle count as pending too
        eff_sof       = pend_sof || sof_in;
        eff_clr       = pend_clr || clear_in;
        issue_addr    = (clear_in || sof_in) ? '0 : cnt_addr;

        cnt_inc = finish;
        cnt_clr = 1'b0;
        if (state == IDLE) begin
            cnt_clr = clear_in || sof_in;
        end else if (finish) begin
            cnt_clr = eff_clr || eff_sof;
        end
    end

    assign busy_out = (state != IDLE) || clear_mode;
    assign rw_out   = 1'b0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= IDLE;
            clear_mode      <= 1'b0;
            clear_color     <= '0;
            pend_sof        <= 1'b0;
            pend_clr        <= 1'b0;
            tmo_cnt         <= '0;
            trig_out        <= 1'b0;
            addr_out        <= '0;
            w_data_out      <= '0;
            frame_done_out  <= 1'b0;
            err_timeout_out <= 1'b0;
        end else begin
            trig_out       <= 1'b0;
            frame_done_out <= cnt_wrap;
            if (timed_out) begin
                err_timeout_out <= 1'b1;
            end

            // Frame-control requests during a transaction are held until it ends
            if (state != IDLE) begin
                if (clear_in) begin
                    pend_clr    <= 1'b1;
                    clear_color <= clear_color_in;
                end
                if (sof_in) begin
                    pend_sof <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (clear_in) begin
                        clear_mode  <= 1'b1;
                        clear_color <= clear_color_in;
                        addr_out    <= '0;
                        w_data_out  <= clear_color_in;
                        trig_out    <= 1'b1;
                        state       <= ISSUE;
                    end else if (clear_mode) begin
                        addr_out   <= issue_addr;
                        w_data_out <= clear_color;
                        trig_out   <= 1'b1;
                        state      <= ISSUE;
                    end else if (accept_pix) begin
                        addr_out   <= issue_addr;
                        w_data_out <= pix_data_in;
                        trig_out   <= 1'b1;
                        state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end

                WAIT: begin
                    if (finish) begin
                        state    <= IDLE;
                        pend_sof <= 1'b0;
                        pend_clr <= 1'b0;
                        if (eff_clr) begin
                            clear_mode <= 1'b1;
                        end else if (cnt_wrap) begin
                            clear_mode <= 1'b0;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Write-side client of the SRAM framebuffer that the VGA scan-out path reads.
- Accepts an RGB332 pixel stream over a valid/ready handshake.
- Issues byte-write transactions to the SRAM controller request interface at sequential framebuffer addresses, wrapping at frame size.
- Also supports a hardware clear mode that fills the whole frame with one colour.

Parameters:
- FRAME_PIXELS, 480000, pixels (bytes) per frame; address range 0..FRAME_PIXELS-1.
- ADDR_W, 19, framebuffer byte-address width.
- DATA_W, 8, pixel width (RGB332: [7:5] blue, [4:3] green, [2:0] red).
- TIMEOUT, 255, max cycles to wait for done_in before abandoning a transaction.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- sof_in  in  1  start-of-frame; next pixel goes to address 0
- pix_valid_in  in  1  pixel present
- pix_data_in  in  DATA_W  pixel value
- pix_ready_out  out  1  writer can accept a pixel this cycle
- clear_in  in  1  pulse; start full-frame fill
- clear_color_in  in  DATA_W  fill value, sampled when clear_in is accepted
- busy_out  out  1  transaction or clear in progress
- frame_done_out  out  1  one-cycle pulse after address FRAME_PIXELS-1 is written
- err_timeout_out  out  1  sticky; set on timeout, cleared only by reset
- trig_out  out  1  one-cycle SRAM request pulse
- rw_out  out  1  always 0 (write)
- addr_out  out  ADDR_W  byte address; stable from trig_out until done_in
- w_data_out  out  DATA_W  write data; stable from trig_out until done_in
- done_in  in  1  one-cycle completion pulse from the SRAM controller

Behaviour:
- Reset (rst=0 at a clock edge), effective the same edge:
  - state=IDLE; address counter=0; trig_out=0; rw_out=0; addr_out=0; w_data_out=0.
  - pix_ready_out=0 during reset; busy_out=0; frame_done_out=0; err_timeout_out=0; clear mode off; pending-sof=0.
  - A transaction in flight is dropped. Any late done_in is ignored, because it only counts in WAIT.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - pix_ready_out=1 unless clear mode is active.
  - Accept priority, same cycle: clear_in > sof_in > pixel.
  - clear_in: address counter:=0; latch clear_color_in; clear mode on; go to ISSUE with that colour. Any coincident pixel is not accepted (ready is forced 0 that cycle).
  - sof_in without a pixel: address counter:=0, stay in IDLE.
  - sof_in with a pixel: the pixel is written to address 0.
  - pix_valid_in & pix_ready_out: latch data and address into addr_out/w_data_out; go to ISSUE.
  - In clear mode, IDLE immediately reissues at the next address with the clear colour.
- ISSUE: trig_out=1 for exactly one cycle; go to WAIT; timeout counter:=0.
- WAIT:
  - Hold addr_out/w_data_out.
  - On done_in:
    - If address=FRAME_PIXELS-1: counter:=0 and frame_done_out pulses the next cycle. If in clear mode, clear mode ends.
    - Otherwise counter+1.
    - Return to IDLE.
  - If the timeout counter reaches TIMEOUT without done_in: set err_timeout_out, advance the address as if done, return to IDLE.
- sof_in or clear_in arriving in ISSUE/WAIT:
  - Latched as pending and applied on return to IDLE, taking precedence over the normal increment.
  - A pending clear overrides a pending sof.
- busy_out = (state≠IDLE) | clear mode.
- Latency: pixel accepted at edge N → trig_out high cycle N+1 → IDLE on the cycle after done_in. Throughput: one pixel per controller latency + 2 cycles.
- Address arithmetic:
  - Unsigned ADDR_W.
  - Never exceeds FRAME_PIXELS-1.
  - Wrap is an explicit compare, not natural overflow.

Decomposition:
- Shared package:
  - FRAME_PIXELS, ADDR_W, DATA_W.
  - RGB332 field positions/widths (RED_LSB=0, GREEN_LSB=3, BLUE_LSB=5).
  - FSM state encoding.
  - The VGA scan-out path uses the same package.
- One natural sub-module: fb_addr_counter. It holds the wrapping address counter with clear/increment/sof inputs and a wrap pulse output; the FSM sequences it.

Test Plan:
- Reset: hold rst=0 3 cycles with pix_valid_in=1 → trig_out=0, pix_ready_out=0, addr_out=0, err_timeout_out=0. Release → pix_ready_out=1 next cycle.
- Single write: pixel 0xA5 accepted; done_in 4 cycles after trig_out → exactly one trig_out pulse with addr_out=0, w_data_out=0xA5, rw_out=0; next pixel goes to addr 1.
- Wrap: preload by writing 479999 pixels (or force counter) then write 0x3C → addr_out=479999, frame_done_out pulses once after done_in, next write at addr 0.
- sof mid-frame: sof_in asserted during WAIT at addr 100 → after done_in the next pixel is written to addr 0, not 101.
- Clear: clear_in with clear_color_in=0xE0 → pix_ready_out=0 throughout; 480000 trig_out pulses at addrs 0..479999 with data 0xE0; one frame_done_out; busy_out falls; ready returns.
- Timeout: never assert done_in → after 255 WAIT cycles err_timeout_out=1 and stays 1; the FSM accepts the next pixel at the next address; a late done_in is ignored.
